// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes and NZCV flag indices shared by the condition logic
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluation against NZCV flags
module cond_eval
    import cond_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    logic n, z, c, v;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        cond_true = 1'b1;
        case (cond)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = c & ~z;
            COND_LS: cond_true = ~c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            // AL and the 1111 encoding both execute unconditionally
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/condlogic_pipe.sv
// rtl/condlogic_pipe.sv - Execute-stage NZCV flags, condition gating and squash counter (optional shadow: CONDLOGIC_SHADOW_EN)
module condlogic_pipe
    import cond_pkg::*;
#(
    parameter int NUM_GROUPS = 2,
    parameter int CTRL_W     = 3,
    parameter int COUNT_W    = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic [3:0]            CondE,
    input  logic [3:0]            ALUFlags,
    input  logic [NUM_GROUPS-1:0] FlagWriteE,
    input  logic [CTRL_W-1:0]     CtrlE,
    input  logic                  SaveFlags,
    input  logic                  RestoreFlags,
    output logic [3:0]            Flags,
    output logic                  CondExE,
    output logic [NUM_GROUPS-1:0] FlagWriteGatedE,
    output logic [CTRL_W-1:0]     CtrlGatedE,
    output logic [COUNT_W-1:0]    SquashCount
);

    localparam int GW = 4 / NUM_GROUPS;

    if (!(NUM_GROUPS == 1 || NUM_GROUPS == 2 || NUM_GROUPS == 4)) begin : g_bad_groups
        $fatal(1, "condlogic_pipe: NUM_GROUPS must be 1, 2 or 4");
    end

    logic cond_true;
    logic ex;
    logic [GW-1:0] grp_q [NUM_GROUPS];

    // Evaluated against registered flags; forwarding of ALUFlags is not done here
    cond_eval u_cond_eval (
        .cond      (cond_e'(CondE)),
        .flags     (Flags),
        .cond_true (cond_true)
    );

    assign CondExE         = cond_true & ~FlushE;
    assign ex              = CondExE & ~StallE;
    assign FlagWriteGatedE = FlagWriteE & {NUM_GROUPS{ex}};
    assign CtrlGatedE      = CtrlE & {CTRL_W{CondExE}};

`ifdef CONDLOGIC_SHADOW_EN
    logic [3:0] shadow_q;

    // Save samples pre-edge Flags while restore loads pre-edge shadow, so both together swap
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            shadow_q <= 4'b0000;
        end else if (SaveFlags) begin
            shadow_q <= Flags;
        end
    end
`else
    logic unused_shadow_ctl;
    assign unused_shadow_ctl = &{1'b0, SaveFlags, RestoreFlags};
`endif

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        always_ff @(posedge CLK) begin
            if (!Reset) begin
                grp_q[g] <= '0;
`ifdef CONDLOGIC_SHADOW_EN
            end else if (RestoreFlags) begin
                grp_q[g] <= shadow_q[g*GW +: GW];
`endif
            end else if (FlagWriteGatedE[g]) begin
                grp_q[g] <= ALUFlags[g*GW +: GW];
            end
        end
        assign Flags[g*GW +: GW] = grp_q[g];
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            SquashCount <= '0;
        end else if (~StallE && ~FlushE && ~cond_true && (SquashCount != {COUNT_W{1'b1}})) begin
            SquashCount <= SquashCount + 1'b1;
        end
    end

endmodule

// File: doc/condlogic_pipe.md
# condlogic_pipe

Parametrised Execute-stage condition unit for the pipelined CPU. Holds the architectural NZCV flags in independently writable groups and evaluates the 4-bit condition field of the instruction in Execute against them. Gates the instruction's side-effect controls by the result, honours stall/flush, keeps a saturating count of condition-failed instructions, and optionally saves and restores flags through a shadow register.

## Interface
Parameters:
- NUM_GROUPS, 2, number of flag write groups. Legal values are 1, 2 and 4. The group width is GW = 4/NUM_GROUPS. Group g covers Flags[(g+1)*GW-1 : g*GW]; with the default, group 1 = NZ and group 0 = CV.
- CTRL_W, 3, width of the control bundle gated by the condition result (e.g. PCSrc, RegWrite, MemWrite).
- COUNT_W, 16, width of the squash counter.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset).
- StallE  in  1  Execute is held; no state update.
- FlushE  in  1  Execute holds a bubble.
- CondE  in  4  condition field of the instruction in Execute.
- ALUFlags  in  4  NZCV produced by the ALU this cycle.
- FlagWriteE  in  NUM_GROUPS  per-group flag write request.
- CtrlE  in  CTRL_W  ungated control bundle.
- SaveFlags  in  1  copy Flags into the shadow (macro only).
- RestoreFlags  in  1  load Flags from the shadow (macro only).
- Flags  out  4  architectural NZCV register.
- CondExE  out  1  instruction in Execute passes its condition.
- FlagWriteGatedE  out  NUM_GROUPS  effective per-group flag write.
- CtrlGatedE  out  CTRL_W  CtrlE with every bit ANDed with the effective-execute signal.
- SquashCount  out  COUNT_W  saturating count of condition-failed instructions.

## Operation
- Condition codes follow ARM encoding: 0000 EQ … 1101 LE.
  - 1110 (AL) is always true.
  - 1111 is treated as unconditional (true).
- The condition is evaluated against the registered Flags, not against ALUFlags.
- CondExE = cond_true & ~FlushE.
- Effective execute: ex = CondExE & ~StallE.
- FlagWriteGatedE[g] = FlagWriteE[g] & ex.
- CtrlGatedE = CtrlE & {CTRL_W{CondExE}}. Stall does not gate controls; the pipeline hazard unit owns that.
- Flag update at a clock edge with Reset=1: group g loads ALUFlags group bits when FlagWriteGatedE[g]=1; otherwise it holds.
- Squash counter increments at the edge when ~StallE & ~FlushE & ~cond_true. It saturates at all-ones and never wraps.
- Reset=0 at an edge:
  - Flags = 0000, shadow = 0000, SquashCount = 0.
  - Reset overrides every other input in the same cycle.
- Outputs are combinational from state and inputs. Immediately after reset, CondE=EQ gives CondExE=0 and CondE=NE gives CondExE=1.

## Timing
- Flag write latency is 1 cycle. The instruction immediately following a flag-setting instruction sees the new Flags in its own Execute cycle with no bubble.
- StallE=1 holds Flags, shadow and counter; combinational outputs still reflect the current inputs.
- StallE and FlushE both high: flush dominates, so CondExE=0 and there is no update.
- With the macro enabled, priority per group at the edge is RestoreFlags > ALU write > hold.
- SaveFlags always captures the pre-edge Flags value.
- SaveFlags and RestoreFlags in the same cycle swap Flags and the shadow.
- Save and restore ignore StallE and FlushE; they are exception-sequencer commands.

## Configuration
- Macro CONDLOGIC_SHADOW_EN.
- Defined: the 4-bit shadow register and the save/restore logic are present as specified.
- Undefined:
  - The ports still exist; SaveFlags and RestoreFlags are ignored.
  - No shadow flops are synthesised.
  - Flags update only from ALU writes.

## Structure
- Shared package cond_pkg holds:
  - cond_e, a 4-bit enum of the 16 codes;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, cond_eval: (cond_e, 4-bit flags) -> cond_true. It is reused by future branch-prediction checks.
- Group registers are written in a generate loop over NUM_GROUPS. Elaboration fails for illegal NUM_GROUPS.

## Test plan
- Reset=0 for 2 cycles, then Reset=1 with CondE=EQ -> Flags=0000, CondExE=0, SquashCount=0.
- Write flags, then condition on them:
  - Cycle 1: CondE=AL, FlagWriteE=11, ALUFlags=0100.
  - Cycle 2: CondE=EQ.
  - Expect Flags=0100 after the edge, CondExE=1 in cycle 2, CtrlGatedE=CtrlE.
- Partial group write: Flags=1111, FlagWriteE=10, ALUFlags=0000, cond passes -> Flags=0011.
- Failed condition: Flags=0000, CondE=EQ with FlagWriteE=11 for 3 cycles -> FlagWriteGatedE=00, CtrlGatedE=0, SquashCount=3, Flags unchanged. Repeat with StallE=1 -> count holds.
- Counter saturation: COUNT_W=2 with 5 failed instructions -> SquashCount stays 3.
- Shadow (macro on):
  - Save at Flags=1010, then write 0101, then restore -> Flags=1010.
  - Restore with a simultaneous ALU write -> restore wins.
  - Save and restore together -> swap.
  - Macro off -> Flags=0101 after the same sequence.
